// File: rtl/mos6502_muxbus_pkg.sv
// Shared types and helpers for the 6502 multiplexed-bus bridge.
// Optional address-chunk cache in the top is enabled by MUXBUS_ADDR_CACHE_EN.
package mos6502_muxbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } mb_state_e;

  // Beat counts for the default 16-bit address / 8-bit data / 8-pin bus build.
  localparam int ABEATS = 16 / 8;
  localparam int DBEATS = 8 / 8;

  // Width of a register that indexes 0..beats-1; never narrower than one bit.
  function automatic int beat_idx_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/muxbus_wait_timer.sv
// Per-beat wait-state down-counter: load sets the count, busy while non-zero.
// Load wins over decrement so a new beat always starts from the full count.
module muxbus_wait_timer #(
  parameter int WS_W = 4
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            load_i,
  input  logic            en_i,
  input  logic [WS_W-1:0] ws_i,
  output logic            busy_o
);

  logic [WS_W-1:0] cnt_q;
  logic [WS_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = ws_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - WS_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/mos6502_muxbus_bridge.sv
// Bridges the 6502 core to a narrow time-multiplexed address/data bus with wait states.
// Define MUXBUS_ADDR_CACHE_EN to skip re-sending unchanged upper address chunks.
module mos6502_muxbus_bridge
  import mos6502_muxbus_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int IO_W   = 8,
  parameter int WS_W   = 4
) (
  input  logic                   wb_clk_i,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      cpu_ab,
  input  logic [DATA_W-1:0]      cpu_do,
  input  logic                   cpu_we,
  output logic [DATA_W-1:0]      cpu_di,
  output logic                   cpu_rdy,
  input  logic [WS_W-1:0]        cfg_ws,
  input  logic [IO_W-1:0]        bus_in,
  output logic [IO_W-1:0]        bus_out,
  output logic [IO_W-1:0]        bus_oeb,
  output logic [ADDR_W/IO_W-1:0] bus_ale,
  output logic                   bus_oe_n,
  output logic                   bus_we_n,
  input  logic                   bus_wait,
  output mb_state_e              dbg_state_o
);

  localparam int NAB = ADDR_W / IO_W;
  localparam int NDB = DATA_W / IO_W;
  localparam int AIW = beat_idx_w(NAB);
  localparam int DIW = beat_idx_w(NDB);

  mb_state_e         state_q, state_d;
  logic [AIW-1:0]    abeat_q, abeat_d;
  logic [DIW-1:0]    dbeat_q, dbeat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              we_q, we_d;
  logic [WS_W-1:0]   ws_q, ws_d;
  logic              tmr_load, tmr_busy, skip_upper;

  logic [DATA_W-1:0] di_d;
  logic              rdy_d, oe_n_d, we_n_d;
  logic [IO_W-1:0]   out_d, oeb_d;
  logic [NAB-1:0]    ale_d;

  muxbus_wait_timer #(.WS_W(WS_W)) u_timer (
    .clk_i   (wb_clk_i),
    .reset_i (reset),
    .load_i  (tmr_load),
    .en_i    (state_q == ST_DATA),
    .ws_i    (ws_q),
    .busy_o  (tmr_busy)
  );

`ifdef MUXBUS_ADDR_CACHE_EN
  logic [ADDR_W-1:IO_W] cache_q;
  logic                 cache_vld_q;

  // Tracks the upper chunks of the access being latched, i.e. the ones last put on the bus.
  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      cache_q     <= '0;
      cache_vld_q <= 1'b0;
    end else if ((state_q == ST_IDLE) || (state_q == ST_DONE)) begin
      cache_q     <= cpu_ab[ADDR_W-1:IO_W];
      cache_vld_q <= 1'b1;
    end
  end

  assign skip_upper = cache_vld_q && (cpu_ab[ADDR_W-1:IO_W] == cache_q);
`else
  assign skip_upper = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      abeat_q  <= '0;
      dbeat_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      we_q     <= 1'b0;
      ws_q     <= '0;
      cpu_rdy  <= 1'b0;
      cpu_di   <= '0;
      bus_out  <= '0;
      bus_oeb  <= '1;
      bus_ale  <= '0;
      bus_oe_n <= 1'b1;
      bus_we_n <= 1'b1;
    end else begin
      state_q  <= state_d;
      abeat_q  <= abeat_d;
      dbeat_q  <= dbeat_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      we_q     <= we_d;
      ws_q     <= ws_d;
      cpu_rdy  <= rdy_d;
      cpu_di   <= di_d;
      bus_out  <= out_d;
      bus_oeb  <= oeb_d;
      bus_ale  <= ale_d;
      bus_oe_n <= oe_n_d;
      bus_we_n <= we_n_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    abeat_d  = abeat_q;
    dbeat_d  = dbeat_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    we_d     = we_q;
    ws_d     = ws_q;
    tmr_load = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        addr_d  = cpu_ab;
        wdata_d = cpu_do;
        we_d    = cpu_we;
        ws_d    = cfg_ws;
        state_d = ST_ADDR;
        abeat_d = skip_upper ? '0 : AIW'(NAB - 1);
      end
      ST_ADDR: begin
        if (abeat_q == '0) begin
          state_d  = ST_DATA;
          dbeat_d  = DIW'(NDB - 1);
          tmr_load = 1'b1;
        end else begin
          abeat_d = abeat_q - AIW'(1);
        end
      end
      ST_DATA: begin
        // bus_wait only matters once the programmed wait states have elapsed.
        if (!tmr_busy && !bus_wait) begin
          if (!we_q) begin
            rdata_d[int'(dbeat_q)*IO_W +: IO_W] = bus_in;
          end
          if (dbeat_q == '0) begin
            state_d = ST_DONE;
          end else begin
            dbeat_d  = dbeat_q - DIW'(1);
            tmr_load = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up with state_q.
  always_comb begin
    rdy_d  = 1'b0;
    di_d   = cpu_di;
    out_d  = '0;
    oeb_d  = '1;
    ale_d  = '0;
    oe_n_d = 1'b1;
    we_n_d = 1'b1;
    unique case (state_d)
      ST_ADDR: begin
        out_d          = addr_d[int'(abeat_d)*IO_W +: IO_W];
        oeb_d          = '0;
        ale_d[abeat_d] = 1'b1;
      end
      ST_DATA: begin
        if (we_d) begin
          out_d  = wdata_d[int'(dbeat_d)*IO_W +: IO_W];
          oeb_d  = '0;
          we_n_d = 1'b0;
        end else begin
          oe_n_d = 1'b0;
        end
      end
      ST_DONE: begin
        rdy_d = 1'b1;
        di_d  = rdata_d;
      end
      default: ;
    endcase
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mos6502_muxbus_bridge.sv
// Randomized bench for the mux-bus bridge: an 8-pin and a 4-pin instance, each checked
// cycle by cycle against a transaction-level model of the bus protocol.
module tb_mos6502_muxbus_bridge;
  import mos6502_muxbus_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] cpu_ab;
  logic [7:0]  cpu_do;
  logic        cpu_we;
  logic [3:0]  cfg_ws;
  logic [7:0]  bus_in;
  logic        bus_wait;

  logic [7:0] a_di, a_out, a_oeb;
  logic [1:0] a_ale;
  logic       a_rdy, a_oe_n, a_we_n;
  mb_state_e  a_state;

  logic [7:0] b_di;
  logic [3:0] b_out, b_oeb, b_ale;
  logic       b_rdy, b_oe_n, b_we_n;
  mb_state_e  b_state;

  int         sel;
  logic [7:0] o_di, o_out, o_oeb;
  logic [3:0] o_ale;
  logic       o_rdy, o_oe_n, o_we_n;

  int          n_checks = 0;
  int          n_errors = 0;
  logic        cache_valid;
  logic [15:0] last_ab;
  logic [7:0]  last_rd;

  mos6502_muxbus_bridge #(.ADDR_W(16), .DATA_W(8), .IO_W(8), .WS_W(4)) dut_a (
    .wb_clk_i(clk), .reset(rst), .cpu_ab(cpu_ab), .cpu_do(cpu_do), .cpu_we(cpu_we),
    .cpu_di(a_di), .cpu_rdy(a_rdy), .cfg_ws(cfg_ws), .bus_in(bus_in), .bus_out(a_out),
    .bus_oeb(a_oeb), .bus_ale(a_ale), .bus_oe_n(a_oe_n), .bus_we_n(a_we_n),
    .bus_wait(bus_wait), .dbg_state_o(a_state)
  );

  mos6502_muxbus_bridge #(.ADDR_W(16), .DATA_W(8), .IO_W(4), .WS_W(4)) dut_b (
    .wb_clk_i(clk), .reset(rst), .cpu_ab(cpu_ab), .cpu_do(cpu_do), .cpu_we(cpu_we),
    .cpu_di(b_di), .cpu_rdy(b_rdy), .cfg_ws(cfg_ws), .bus_in(bus_in[3:0]), .bus_out(b_out),
    .bus_oeb(b_oeb), .bus_ale(b_ale), .bus_oe_n(b_oe_n), .bus_we_n(b_we_n),
    .bus_wait(bus_wait), .dbg_state_o(b_state)
  );

  always_comb begin
    if (sel == 0) begin
      o_di = a_di; o_out = a_out; o_oeb = a_oeb; o_ale = {2'b00, a_ale};
      o_rdy = a_rdy; o_oe_n = a_oe_n; o_we_n = a_we_n;
    end else begin
      o_di = b_di; o_out = {4'h0, b_out}; o_oeb = {4'h0, b_oeb}; o_ale = b_ale;
      o_rdy = b_rdy; o_oe_n = b_oe_n; o_we_n = b_we_n;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (io_w=%0d, t=%0t): got %0h expected %0h", tag, (sel == 0) ? 8 : 4,
               $time, got, exp);
    end
  endtask

  task automatic check_ctrl(input string tag, input logic rdy, input logic [3:0] ale,
                            input logic oe_n, input logic we_n, input logic [7:0] oeb);
    check(tag, {17'd0, o_rdy, o_ale, o_oe_n, o_we_n, o_oeb},
               {17'd0, rdy, ale, oe_n, we_n, oeb});
  endtask

  // Call at a negedge; leaves the bench at the negedge of the idle cycle after reset.
  task automatic do_reset(input int n);
    logic [7:0] mask;
    mask = (sel == 0) ? 8'hFF : 8'h0F;
    rst = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_ctrl("reset_ctrl", 1'b0, 4'h0, 1'b1, 1'b1, mask);
    check("reset_out", 32'(o_out), 32'h0);
    check("reset_di", 32'(o_di), 32'h0);
    cache_valid = 1'b0;
    last_ab     = '0;
    last_rd     = '0;
  endtask

  // Call at the negedge of the cycle in which the bridge latches the next access.
  task automatic access(input logic we, input logic [15:0] ab, input logic [7:0] wd,
                        input logic [3:0] ws, input int wait_beat, input int wait_len);
    int         iow, nab, ndb, first, ncyc, extra;
    logic [7:0] mask, rd, sh, chunk;
    logic       hit;
    iow  = (sel == 0) ? 8 : 4;
    nab  = 16 / iow;
    ndb  = 8 / iow;
    mask = (sel == 0) ? 8'hFF : 8'h0F;
    rd   = last_rd;
    hit  = 1'b0;
`ifdef MUXBUS_ADDR_CACHE_EN
    hit = cache_valid && ((ab >> iow) == (last_ab >> iow));
`endif
    cache_valid = 1'b1;
    last_ab     = ab;
    cpu_ab = ab; cpu_do = wd; cpu_we = we; cfg_ws = ws;
    first = hit ? 0 : nab - 1;
    @(posedge clk);
    for (int k = first; k >= 0; k--) begin
      @(negedge clk);
      cfg_ws   = 4'($urandom_range(0, 15));
      cpu_ab   = 16'($urandom);
      cpu_do   = 8'($urandom);
      cpu_we   = 1'($urandom);
      bus_wait = 1'($urandom);
      bus_in   = 8'($urandom);
      chunk    = 8'((ab >> (k * iow)) & {8'h00, mask});
      check_ctrl("addr_ctrl", 1'b0, 4'(1 << k), 1'b1, 1'b1, 8'h00);
      check("addr_out", 32'(o_out), 32'(chunk));
    end
    for (int b = ndb - 1; b >= 0; b--) begin
      extra = (b == wait_beat) ? wait_len : 0;
      ncyc  = int'(ws) + extra + 1;
      for (int c = 0; c < ncyc; c++) begin
        @(negedge clk);
        bus_in = 8'($urandom);
        if (c < int'(ws)) bus_wait = 1'($urandom);
        else              bus_wait = (c < ncyc - 1);
        if (we) begin
          check_ctrl("wr_ctrl", 1'b0, 4'h0, 1'b1, 1'b0, 8'h00);
          chunk = (wd >> (b * iow)) & mask;
          check("wr_out", 32'(o_out), 32'(chunk));
        end else begin
          check_ctrl("rd_ctrl", 1'b0, 4'h0, 1'b0, 1'b1, mask);
        end
        if (!we && (c == ncyc - 1)) begin
          sh = mask << (b * iow);
          rd = (rd & ~sh) | ((bus_in & mask) << (b * iow));
        end
      end
    end
    @(negedge clk);
    bus_wait = 1'b0;
    if (!we) last_rd = rd;
    check_ctrl("done_ctrl", 1'b1, 4'h0, 1'b1, 1'b1, mask);
    check("cpu_di", 32'(o_di), 32'(last_rd));
  endtask

  task automatic random_access(input int ndb);
    logic [15:0] ab;
    ab = 16'($urandom);
    if ($urandom_range(0, 2) == 0) ab[15:4] = last_ab[15:4];
    if ($urandom_range(0, 3) == 0) ab[15:8] = last_ab[15:8];
    access(1'($urandom), ab, 8'($urandom), 4'($urandom_range(0, 3)),
           ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, ndb - 1)),
           int'($urandom_range(0, 3)));
  endtask

  initial begin
    sel = 0; rst = 1'b1;
    cpu_ab = '0; cpu_do = '0; cpu_we = 1'b0; cfg_ws = '0;
    bus_in = '0; bus_wait = 1'b0;
    cache_valid = 1'b0; last_ab = '0; last_rd = '0;
    @(negedge clk);
    do_reset(3);

    access(1'b0, 16'h1234, 8'h00, 4'd0, -1, 0);
    access(1'b1, 16'h00FF, 8'h5A, 4'd2, -1, 0);
    access(1'b0, 16'hC0DE, 8'h00, 4'd0, 0, 5);
    access(1'b0, 16'h7777, 8'h00, 4'd3, 0, 2);

    // Reset in the middle of a stalled read; the next access must start from scratch.
    do_reset(1);
    cpu_ab = 16'h4321; cpu_do = 8'h00; cpu_we = 1'b0; cfg_ws = 4'd1;
    @(posedge clk);
    for (int k = 1; k >= 0; k--) begin
      @(negedge clk);
      bus_wait = 1'b1;
      check_ctrl("abort_addr", 1'b0, 4'(1 << k), 1'b1, 1'b1, 8'h00);
    end
    repeat (4) begin
      @(negedge clk);
      bus_wait = 1'b1;
      check_ctrl("abort_data", 1'b0, 4'h0, 1'b0, 1'b1, 8'hFF);
    end
    do_reset(1);
    bus_wait = 1'b0;

    access(1'b0, 16'h1234, 8'h00, 4'd0, -1, 0);
    access(1'b0, 16'h1256, 8'h00, 4'd0, -1, 0);
    access(1'b1, 16'h12AA, 8'hC3, 4'd1, -1, 0);
    for (int i = 0; i < 40; i++) random_access(1);

    sel = 1;
    do_reset(2);
    access(1'b0, 16'hBEEF, 8'h00, 4'd0, -1, 0);
    access(1'b1, 16'hBEE0, 8'h96, 4'd1, 1, 2);
    access(1'b0, 16'h0BEE, 8'h00, 4'd2, 0, 3);
    for (int i = 0; i < 25; i++) random_access(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
